// File: rtl/mandel_pixel_scheduler.sv
// Mandelbrot frame scheduler: walks the pixel grid column-major, dispatches jobs to N_ENG
// engines and arbitrates their results onto one framebuffer write port. Optional: MANDEL_SCHED_PERF_EN.
//   state   | meaning
//   S_IDLE  | waiting for start, frame parameters latched on start
//   S_RUN   | dispatching pixels and writing back results
//   S_DRAIN | all pixels dispatched, collecting outstanding results
module mandel_pixel_scheduler #(
  parameter int N_ENG = 4,
  parameter int N_BIT = 25,
  parameter int PX_W  = 9,
  parameter int PY_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PX_W-1:0]      pix_x_max,
  input  logic [PY_W-1:0]      pix_y_max,
  input  logic [N_BIT-1:0]     cxs,
  input  logic [N_BIT-1:0]     cys,
  input  logic [N_BIT-1:0]     dcx,
  input  logic [N_BIT-1:0]     dcy,
  output logic                 busy,
  output logic                 done,
  input  logic [N_ENG-1:0]     eng_idle,
  output logic [N_ENG-1:0]     eng_start,
  output logic [N_BIT-1:0]     eng_cx,
  output logic [N_BIT-1:0]     eng_cy,
  input  logic [N_ENG-1:0]     res_valid,
  input  logic [3*N_ENG-1:0]   res_color,
  output logic [N_ENG-1:0]     res_ack,
  output logic [PX_W-1:0]      wx,
  output logic [PY_W-1:0]      wy,
  output logic [2:0]           wd,
  output logic                 we
`ifdef MANDEL_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stall
`endif
);

  localparam int PTR_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PX_W-1:0]   x_max_q, x_max_d, px_q, px_d, wx_q, wx_d;
  logic [PY_W-1:0]   y_max_q, y_max_d, py_q, py_d, wy_q, wy_d;
  logic [N_BIT-1:0]  cxs_q, cxs_d, cys_q, cys_d, dcx_q, dcx_d, dcy_q, dcy_d;
  logic [N_BIT-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic [N_ENG-1:0]  pending_q, pending_d, free;
  logic [PX_W-1:0]   tag_x_q [N_ENG];
  logic [PX_W-1:0]   tag_x_d [N_ENG];
  logic [PY_W-1:0]   tag_y_q [N_ENG];
  logic [PY_W-1:0]   tag_y_d [N_ENG];
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [2:0]        wd_q, wd_d;
  logic              we_q, we_d, done_q, done_d, gnt_any;
  int                gnt_idx;
`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0]       perf_cycles_q, perf_cycles_d, perf_stall_q, perf_stall_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_max_q   <= '0;
      y_max_q   <= '0;
      cxs_q     <= '0;
      cys_q     <= '0;
      dcx_q     <= '0;
      dcy_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      wd_q      <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < N_ENG; i++) begin
        tag_x_q[i] <= '0;
        tag_y_q[i] <= '0;
      end
`ifdef MANDEL_SCHED_PERF_EN
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      x_max_q   <= x_max_d;
      y_max_q   <= y_max_d;
      cxs_q     <= cxs_d;
      cys_q     <= cys_d;
      dcx_q     <= dcx_d;
      dcy_q     <= dcy_d;
      px_q      <= px_d;
      py_q      <= py_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      wd_q      <= wd_d;
      we_q      <= we_d;
      done_q    <= done_d;
      for (int i = 0; i < N_ENG; i++) begin
        tag_x_q[i] <= tag_x_d[i];
        tag_y_q[i] <= tag_y_d[i];
      end
`ifdef MANDEL_SCHED_PERF_EN
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    x_max_d   = x_max_q;
    y_max_d   = y_max_q;
    cxs_d     = cxs_q;
    cys_d     = cys_q;
    dcx_d     = dcx_q;
    dcy_d     = dcy_q;
    px_d      = px_q;
    py_d      = py_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    rr_d      = rr_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    wd_d      = wd_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    eng_start = '0;
    res_ack   = '0;
    gnt_any   = 1'b0;
    gnt_idx   = 0;
    tag_x_d   = tag_x_q;
    tag_y_d   = tag_y_q;
    free      = eng_idle & ~pending_q;
`ifdef MANDEL_SCHED_PERF_EN
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q != S_IDLE) perf_cycles_d = perf_cycles_q + 32'd1;
    if (state_q == S_RUN && free == '0) perf_stall_d = perf_stall_q + 32'd1;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_max_d = pix_x_max;
          y_max_d = pix_y_max;
          cxs_d   = cxs;
          cys_d   = cys;
          dcx_d   = dcx;
          dcy_d   = dcy;
          px_d    = '0;
          py_d    = '0;
          cx_d    = cxs;
          cy_d    = cys;
          state_d = S_RUN;
`ifdef MANDEL_SCHED_PERF_EN
          perf_cycles_d = '0;
          perf_stall_d  = '0;
`endif
        end
      end
      S_RUN: begin
        if (free != '0) begin
          // Lowest set bit of free selects the engine.
          eng_start = free & (~free + N_ENG'(1));
          for (int i = 0; i < N_ENG; i++) begin
            if (eng_start[i]) begin
              tag_x_d[i] = px_q;
              tag_y_d[i] = py_q;
            end
          end
          if (py_q == y_max_q) begin
            py_d = '0;
            cy_d = cys_q;
            px_d = px_q + PX_W'(1);
            cx_d = cx_q + dcx_q;
            if (px_q == x_max_q) state_d = S_DRAIN;
          end else begin
            py_d = py_q + PY_W'(1);
            cy_d = cy_q + dcy_q;
          end
        end
      end
      S_DRAIN: begin
        if (pending_q == '0 && !we_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      for (int k = 0; k < N_ENG; k++) begin
        if (!gnt_any && res_valid[(int'(rr_q) + k) % N_ENG] && pending_q[(int'(rr_q) + k) % N_ENG]) begin
          gnt_any = 1'b1;
          gnt_idx = (int'(rr_q) + k) % N_ENG;
        end
      end
      if (gnt_any) begin
        res_ack[gnt_idx] = 1'b1;
        we_d = 1'b1;
        wx_d = tag_x_q[gnt_idx];
        wy_d = tag_y_q[gnt_idx];
        wd_d = res_color[3*gnt_idx +: 3];
        rr_d = PTR_W'((gnt_idx + 1) % N_ENG);
      end
    end

    pending_d = (pending_q | eng_start) & ~res_ack;
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign eng_cx = cx_q;
  assign eng_cy = cy_q;
  assign wx     = wx_q;
  assign wy     = wy_q;
  assign wd     = wd_q;
  assign we     = we_q;
`ifdef MANDEL_SCHED_PERF_EN
  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench for mandel_pixel_scheduler: a 1-engine instance and a 4-engine instance
// driven by hand-sequenced engine behaviour with hand-computed expectations.
module tb_mandel_pixel_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  x_max = '0;
  logic [7:0]  y_max = '0;
  logic [24:0] cxs = '0, cys = '0, dcx = '0, dcy = '0;

  logic        start_a = 1'b0, busy_a, done_a, we_a;
  logic [0:0]  eng_idle_a = '0, eng_start_a, res_valid_a = '0, res_ack_a;
  logic [2:0]  res_color_a = '0, wd_a;
  logic [24:0] eng_cx_a, eng_cy_a;
  logic [8:0]  wx_a;
  logic [7:0]  wy_a;

  logic        start_b = 1'b0, busy_b, done_b, we_b;
  logic [3:0]  eng_idle_b = '0, eng_start_b, res_valid_b = '0, res_ack_b;
  logic [11:0] res_color_b = '0;
  logic [2:0]  wd_b;
  logic [24:0] eng_cx_b, eng_cy_b;
  logic [8:0]  wx_b;
  logic [7:0]  wy_b;
`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0] perf_cycles_a, perf_stall_a, perf_cycles_b, perf_stall_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mandel_pixel_scheduler #(.N_ENG(1), .N_BIT(25), .PX_W(9), .PY_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a), .pix_x_max(x_max), .pix_y_max(y_max),
    .cxs(cxs), .cys(cys), .dcx(dcx), .dcy(dcy), .busy(busy_a), .done(done_a),
    .eng_idle(eng_idle_a), .eng_start(eng_start_a), .eng_cx(eng_cx_a), .eng_cy(eng_cy_a),
    .res_valid(res_valid_a), .res_color(res_color_a), .res_ack(res_ack_a),
    .wx(wx_a), .wy(wy_a), .wd(wd_a), .we(we_a)
`ifdef MANDEL_SCHED_PERF_EN
    , .perf_cycles(perf_cycles_a), .perf_stall(perf_stall_a)
`endif
  );

  mandel_pixel_scheduler #(.N_ENG(4), .N_BIT(25), .PX_W(9), .PY_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_b), .pix_x_max(x_max), .pix_y_max(y_max),
    .cxs(cxs), .cys(cys), .dcx(dcx), .dcy(dcy), .busy(busy_b), .done(done_b),
    .eng_idle(eng_idle_b), .eng_start(eng_start_b), .eng_cx(eng_cx_b), .eng_cy(eng_cy_b),
    .res_valid(res_valid_b), .res_color(res_color_b), .res_ack(res_ack_b),
    .wx(wx_b), .wy(wy_b), .wd(wd_b), .we(we_b)
`ifdef MANDEL_SCHED_PERF_EN
    , .perf_cycles(perf_cycles_b), .perf_stall(perf_stall_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 2x2 frame on the 4-engine instance, origin 0, step 1, all engines idle.
  task automatic run_quad(input string tag);
    x_max = 9'd1; y_max = 8'd1; cxs = '0; cys = '0; dcx = 25'd1; dcy = 25'd1;
    eng_idle_b = 4'hF; res_valid_b = '0; start_b = 1'b1;
    tick();
    start_b = 1'b0; #1;
    check({tag, "_d0"}, {eng_start_b, eng_cx_b, eng_cy_b}, {4'b0001, 25'd0, 25'd0});
    tick();
    check({tag, "_d1"}, {eng_start_b, eng_cx_b, eng_cy_b}, {4'b0010, 25'd0, 25'd1});
    tick();
    check({tag, "_d2"}, {eng_start_b, eng_cx_b, eng_cy_b}, {4'b0100, 25'd1, 25'd0});
    tick();
    check({tag, "_d3"}, {eng_start_b, eng_cx_b, eng_cy_b}, {4'b1000, 25'd1, 25'd1});
    tick();
    res_color_b = {3'd4, 3'd3, 3'd2, 3'd1}; res_valid_b = 4'hF; #1;
    check({tag, "_drain_nostart"}, {busy_b, eng_start_b}, {1'b1, 4'b0000});
    check({tag, "_ack0"}, res_ack_b, 4'b0001);
    tick();
    res_valid_b = 4'hE; #1;
    check({tag, "_w0"}, {we_b, wx_b, wy_b, wd_b, res_ack_b}, {1'b1, 9'd0, 8'd0, 3'd1, 4'b0010});
    tick();
    res_valid_b = 4'hC; #1;
    check({tag, "_w1"}, {we_b, wx_b, wy_b, wd_b, res_ack_b}, {1'b1, 9'd0, 8'd1, 3'd2, 4'b0100});
    tick();
    res_valid_b = 4'h8; #1;
    check({tag, "_w2"}, {we_b, wx_b, wy_b, wd_b, res_ack_b}, {1'b1, 9'd1, 8'd0, 3'd3, 4'b1000});
    tick();
    res_valid_b = 4'h0; #1;
    check({tag, "_w3"}, {we_b, wx_b, wy_b, wd_b, res_ack_b, done_b}, {1'b1, 9'd1, 8'd1, 3'd4, 4'b0000, 1'b0});
    tick();
    check({tag, "_post_we"}, {we_b, done_b}, {1'b0, 1'b0});
    tick();
    check({tag, "_done"}, {done_b, busy_b}, {1'b1, 1'b0});
    tick();
    check({tag, "_done_pulse"}, done_b, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_dut4", {busy_b, done_b, we_b, eng_start_b, wx_b, wy_b, wd_b, eng_cx_b, eng_cy_b}, '0);
    check("rst_dut1", {busy_a, done_a, we_a, eng_start_a, eng_cx_a, eng_cy_a}, '0);
    rst = 1'b0;

    // Single engine, 2x2 frame from (-2.0,-1.0) with step 1/64, colour 5 two cycles after start.
    x_max = 9'd1; y_max = 8'd1;
    cxs = 25'h1E00000; cys = 25'h1F00000; dcx = 25'h0004000; dcy = 25'h0004000;
    eng_idle_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0; #1;
    for (int p = 0; p < 4; p++) begin
      check("t1_dispatch", {busy_a, eng_start_a}, {1'b1, 1'b1});
      check("t1_cx", eng_cx_a, (p < 2) ? 25'h1E00000 : 25'h1E04000);
      check("t1_cy", eng_cy_a, (p % 2 == 0) ? 25'h1F00000 : 25'h1F04000);
      tick();
      eng_idle_a = 1'b0; #1;
      check("t1_no_start", {eng_start_a, we_a}, {1'b0, 1'b0});
      tick();
      res_valid_a = 1'b1; res_color_a = 3'd5; #1;
      check("t1_ack", res_ack_a, 1'b1);
      tick();
      res_valid_a = 1'b0; eng_idle_a = 1'b1; #1;
      check("t1_write", {we_a, wx_a, wy_a, wd_a}, {1'b1, 9'(p / 2), 8'(p % 2), 3'd5});
    end
    check("t1_drain", {busy_a, eng_start_a, done_a}, {1'b1, 1'b0, 1'b0});
    tick();
    check("t1_post_we", {we_a, done_a}, {1'b0, 1'b0});
    tick();
    check("t1_done", {done_a, busy_a}, {1'b1, 1'b0});
    tick();
    check("t1_done_pulse", done_a, 1'b0);

    // Four engines, dispatch order and round-robin write-back.
    run_quad("t2");

    // Stall for 10 cycles with start held high, then round-robin from a non-zero pointer.
    x_max = 9'd0; y_max = 8'd2; cxs = 25'h100; cys = 25'h200; dcx = 25'h10; dcy = 25'h20;
    eng_idle_b = 4'hF; start_b = 1'b1;
    tick();
    start_b = 1'b0; #1;
    check("t3_d0", {eng_start_b, eng_cx_b, eng_cy_b}, {4'b0001, 25'h100, 25'h200});
    tick();
    eng_idle_b = 4'h0; start_b = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      check("t3_stall", {busy_b, eng_start_b, eng_cx_b, eng_cy_b}, {1'b1, 4'b0000, 25'h100, 25'h220});
      tick();
    end
    start_b = 1'b0; eng_idle_b = 4'hF; #1;
    check("t3_d1", {eng_start_b, eng_cy_b}, {4'b0010, 25'h220});
    tick();
    check("t3_d2", {eng_start_b, eng_cy_b}, {4'b0100, 25'h240});
    tick();
    res_color_b = {3'd4, 3'd3, 3'd2, 3'd1}; res_valid_b = 4'b0110; #1;
    check("t3_ack1", {eng_start_b, res_ack_b}, {4'b0000, 4'b0010});
    tick();
    res_valid_b = 4'b0101; #1;
    check("t3_w1", {we_b, wy_b, wd_b, res_ack_b}, {1'b1, 8'd1, 3'd2, 4'b0100});
    tick();
    res_valid_b = 4'b0001; #1;
    check("t3_w2", {we_b, wy_b, wd_b, res_ack_b}, {1'b1, 8'd2, 3'd3, 4'b0001});
    tick();
    res_valid_b = 4'b0000; #1;
    check("t3_w0", {we_b, wx_b, wy_b, wd_b, done_b}, {1'b1, 9'd0, 8'd0, 3'd1, 1'b0});
    tick();
    check("t3_post_we", {we_b, done_b}, {1'b0, 1'b0});
    tick();
    check("t3_done", {done_b, busy_b}, {1'b1, 1'b0});
    tick();
    check("t3_single_done", {done_b, busy_b}, {1'b0, 1'b0});
`ifdef MANDEL_SCHED_PERF_EN
    check("t3_perf_stall", perf_stall_b, 32'd10);
    check("t3_perf_cycles", perf_cycles_b, 32'd18);
`endif

    // Reset in the middle of a frame, while an ack is being granted.
    x_max = 9'd1; y_max = 8'd1; cxs = '0; cys = '0; dcx = 25'd1; dcy = 25'd1;
    eng_idle_b = 4'hF; start_b = 1'b1;
    tick();
    start_b = 1'b0; #1;
    check("t5_d0", eng_start_b, 4'b0001);
    tick();
    check("t5_d1", eng_start_b, 4'b0010);
    tick();
    eng_idle_b = 4'h0; res_valid_b = 4'b0011; #1;
    check("t5_ack_rr", res_ack_b, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0; eng_idle_b = 4'hF; #1;
    check("t5_after_rst", {busy_b, we_b, done_b, res_ack_b, eng_start_b, eng_cx_b, eng_cy_b}, '0);
    tick();
    check("t5_no_write", {we_b, res_ack_b}, '0);
    res_valid_b = 4'h0;
    run_quad("t5");

    // Single-pixel frame.
    x_max = 9'd0; y_max = 8'd0; cxs = 25'd5; cys = 25'd7; eng_idle_b = 4'hF; start_b = 1'b1;
    tick();
    start_b = 1'b0; #1;
    check("t6_dispatch", {busy_b, eng_start_b, eng_cx_b, eng_cy_b}, {1'b1, 4'b0001, 25'd5, 25'd7});
    tick();
    res_valid_b = 4'b0001; res_color_b = 12'd6; #1;
    check("t6_ack", {eng_start_b, res_ack_b}, {4'b0000, 4'b0001});
    tick();
    res_valid_b = 4'b0000; #1;
    check("t6_write", {we_b, wx_b, wy_b, wd_b}, {1'b1, 9'd0, 8'd0, 3'd6});
    tick();
    check("t6_post_we", {we_b, done_b, eng_start_b}, {1'b0, 1'b0, 4'b0000});
    tick();
    check("t6_done", {done_b, busy_b}, {1'b1, 1'b0});
    tick();
    check("t6_done_pulse", done_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_pixel_scheduler.md
Name: mandel_pixel_scheduler

Overview:
Frame-level controller that sequences a Mandelbrot render across N_ENG parallel iteration engines.
- Walks the pixel grid column-major (py inner, px outer) and generates cx/cy incrementally.
- Dispatches each pixel to a free engine.
- Arbitrates engine results round-robin onto the single video framebuffer write port (wx/wy/wd/we).
- Sits between the UART command decoder (start + frame parameters) and the engines/video block.

Parameters:
N_ENG, 4, number of iteration engines (1..8)
N_BIT, 25, fixed-point coordinate width (Q20, two's complement)
PX_W, 9, pixel x width
PY_W, 8, pixel y width

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  begin frame; sampled only in IDLE
pix_x_max  in  PX_W  last column index (inclusive)
pix_y_max  in  PY_W  last row index (inclusive)
cxs, cys  in  N_BIT each  frame origin
dcx, dcy  in  N_BIT each  per-pixel step
busy  out  1  high in RUN/DRAIN
done  out  1  one-cycle pulse at frame end
eng_idle  in  N_ENG  engine i can accept a job
eng_start  out  N_ENG  one-hot one-cycle dispatch strobe
eng_cx, eng_cy  out  N_BIT each  job coordinates, valid with eng_start
res_valid  in  N_ENG  engine i holds a result
res_color  in  3*N_ENG  engine i colour, bits [3i+2:3i]
res_ack  out  N_ENG  one-hot combinational grant/ack
wx  out  PX_W  write x
wy  out  PY_W  write y
wd  out  3  write colour
we  out  1  write strobe

Behaviour:
Reset and clocking:
- rst is synchronous and active-high; clock is clk.
- Reset values: state=IDLE; busy, done, eng_start, we = 0; wx, wy, wd, eng_cx, eng_cy = 0; all internal pending bits and counters = 0; round-robin pointer = 0.
- Reset asserted mid-frame aborts immediately. Outstanding engine results arriving afterwards are acked only once a new frame is running; engines must be reset together with the scheduler.

States:
- IDLE: on start, latch all frame parameters, set px=py=0, cx=cxs, cy=cys, go to RUN next cycle.
- RUN: each cycle, dispatch to the lowest index i with eng_idle[i]=1 and pending[i]=0.
  - Dispatch cycle: eng_start[i]=1, eng_cx=cx, eng_cy=cy; tag_x[i]=px, tag_y[i]=py, pending[i]=1.
  - Coordinate advance on every dispatch: py+1, cy+=dcy.
  - If py==pix_y_max: py=0, cy=cys, px+1, cx+=dcx.
  - If additionally px==pix_x_max: go to DRAIN. This is the last pixel.
  - No free engine: hold all state, eng_start=0.
  - First dispatch is possible in the first RUN cycle.
- DRAIN: no dispatch. When pending==0 and no write is in flight, pulse done for one cycle and go to IDLE.
- start is ignored outside IDLE.

Arithmetic:
- cx/cy additions are modulo 2^N_BIT with no saturation.
- px/py compare against the latched maxima only.
- Maxima are inclusive, so a frame is (pix_x_max+1)*(pix_y_max+1) pixels; 0/0 gives 1 pixel.

Result arbitration (RUN and DRAIN):
- Candidates are res_valid & pending.
- Grant is round-robin starting at the pointer, combinational res_ack in the same cycle.
- Next cycle: we=1, wx=tag_x[g], wy=tag_y[g], wd=res_color[g]; pending[g] clears, pointer = g+1 mod N_ENG.
- At most one grant per cycle.
- Dispatch and ack to the same engine in the same cycle cannot occur, because pending gates dispatch.
- An engine may be re-dispatched the cycle after its ack, if eng_idle.
- done asserts no earlier than the cycle after the final we.

Optional Feature:
MANDEL_SCHED_PERF_EN:
- When defined, adds outputs perf_cycles (32) and perf_stall (32).
  - Both clear on frame start.
  - perf_cycles counts RUN+DRAIN cycles.
  - perf_stall counts RUN cycles with no free engine.
  - Both hold after done; both are 0 after reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. N_ENG=1, pix_x_max=1, pix_y_max=1, cxs=-2.0, cys=-1.0, dcx=dcy=1/64. Engine returns colour 5 two cycles after each start.
   -> Dispatch order (0,0),(0,1),(1,0),(1,1) with cy stepping -1.0, -1+1/64, then reset to -1.0 with cx=-2+1/64. Four we pulses with wd=5. Single done pulse after the last we.
2. N_ENG=4, all engines idle.
   -> eng_start=0001, 0010, 0100, 1000 on consecutive RUN cycles. All four assert res_valid in the same cycle; acks in order 0,1,2,3 over four cycles with correct wx/wy tags.
3. All engines busy (eng_idle=0) for 10 cycles mid-frame.
   -> No eng_start; px/py/cx/cy unchanged; perf_stall +10 with MANDEL_SCHED_PERF_EN.
4. start asserted during RUN.
   -> Ignored; frame completes normally with exactly one done.
5. rst pulsed mid-frame.
   -> Next cycle: state IDLE, busy=0, we=0, pending=0. A new start renders the full frame correctly.
6. pix_x_max=0, pix_y_max=0.
   -> Exactly one dispatch, one we at (0,0), then done.
